pipo_fifo: RTL and testbench
============================

PIPO_FIFO -- requirements
Module: pipo_fifo

Interface
REQ-001 Parameter Width, default 8, data word width in bits (>=1).
REQ-002 Parameter Depth, default 4, number of storage words (power of 2, >=2).
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 clr_i  input  1  synchronous flush, active-high.
REQ-006 wr_i  input  1  write request (enable), samples din_i.
REQ-007 din_i  input  Width  write data.
REQ-008 rd_i  input  1  read request, pops head word.
REQ-009 dout_o  output  Width  head word (show-ahead).
REQ-010 empty_o  output  1  no words stored.
REQ-011 full_o  output  1  Depth words stored.
REQ-012 count_o  output  clog2(Depth)+1  words stored, 0..Depth.
REQ-013 ovf_o  output  1  sticky overflow flag.
REQ-014 udf_o  output  1  sticky underflow flag.

Function
REQ-015 Storage SHALL be Depth x Width words, write pointer and read pointer each clog2(Depth) bits, wrapping Depth-1 -> 0.
REQ-016 Write accepted when wr_i=1 and (full_o=0 or rd_i=1): din_i stored at write pointer, write pointer +1.
REQ-017 Read accepted when rd_i=1 and empty_o=0: read pointer +1.
REQ-018 dout_o SHALL equal the word at the read pointer when empty_o=0, and all-zeros when empty_o=1; zero-cycle latency from pointer (show-ahead).
REQ-019 Word written in cycle N SHALL appear on dout_o after edge N when FIFO was empty (one-cycle write-to-read latency).
REQ-020 count_o: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-021 empty_o = (count_o==0), full_o = (count_o==Depth), both derived from registered count, no glitch paths from inputs.
REQ-022 Full with wr_i=1 and rd_i=1: both accepted, count stays Depth, full_o stays 1.
REQ-023 Full with wr_i=1 and rd_i=0: write dropped, contents unchanged, ovf_o set to 1 at next edge.
REQ-024 Empty with rd_i=1: read ignored, pointers unchanged, udf_o set to 1 at next edge; a simultaneous wr_i is still accepted.
REQ-025 ovf_o and udf_o SHALL remain 1 until rst_i or clr_i.
REQ-026 clr_i=1 SHALL override wr_i and rd_i in the same cycle: pointers, count_o, ovf_o, udf_o to 0 at next edge; storage contents not required to clear.
REQ-027 FIFO order SHALL be preserved across any number of pointer wrap-arounds.

Reset
REQ-028 rst_i=1 SHALL immediately force pointers and count to 0, so that empty_o=1, full_o=0, count_o=0, ovf_o=0, udf_o=0, dout_o=0, independent of clk_i.
REQ-029 Storage array SHALL NOT be reset (register/RAM inference); no output may depend on uninitialised storage while empty.
REQ-030 Reset asserted mid-transfer SHALL discard all stored words; first write after release is treated as into an empty FIFO.

Structure
REQ-031 Shared package/header SHALL hold default Width/Depth constants and the clog2-based pointer/count width helper; no typedefs beyond these.
REQ-032 One sub-module is natural: fifo_ptr, a parametrised clog2(Depth)-bit wrapping counter with increment-enable and synchronous clear, instantiated twice (write and read pointers).
REQ-033 Count register and flag logic SHALL live in pipo_fifo top; total RTL 120-400 lines.

Verification
REQ-034 Reset: assert rst_i with no clock edge -> empty_o=1, full_o=0, count_o=0, dout_o=0x00, ovf_o=udf_o=0 immediately.
REQ-035 Fill/drain (Width=8, Depth=4): write 0x11,0x22,0x33,0x44 -> full_o=1, count_o=4; read 4x -> dout_o 0x11,0x22,0x33,0x44 in order, then empty_o=1, dout_o=0x00.
REQ-036 Overflow: full, write 0x55 with rd_i=0 -> ovf_o=1, count_o=4, subsequent reads return 0x11..0x44 (0x55 absent).
REQ-037 Underflow and simultaneous: empty, rd_i=1 with wr_i=1 din=0xA5 -> udf_o=1, count_o=1, dout_o=0xA5; full with wr_i=rd_i=1 -> count_o stays 4, head advances.
REQ-038 Wrap: 10 iterations of write 3 / read 3 with incrementing data -> every read matches write order, count_o returns 0 each iteration.
REQ-039 Flush: count_o=3, ovf_o=1, clr_i=1 with wr_i=1 -> next edge count_o=0, empty_o=1, ovf_o=0, write not stored.

Source files
------------

// File: rtl/pipo_fifo_pkg.sv
// pipo_fifo_pkg: shared defaults and width helpers for the pipo_fifo slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and storage depth
//   ptr_width(depth)              : bits needed for a wrapping pointer
//   cnt_width(depth)              : bits needed for an occupancy count 0..depth
package pipo_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Pointer width; depth is a power of two >= 2, so clog2 is exact.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent "depth" itself (full).
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: clog2(Depth)-bit wrapping pointer with increment enable and
// synchronous clear.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (pointer -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : advance pointer by one, wrapping Depth-1 -> 0
//   ptr_o  : current pointer value
module fifo_ptr
  import pipo_fifo_pkg::*;
#(
  parameter int Depth = DEFAULT_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [ptr_width(Depth)-1:0] ptr_o
);

  localparam int PW = ptr_width(Depth);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Next pointer: Depth is a power of two, so natural overflow is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = {PW{1'b0}};
    end else if (inc_i) begin
      ptr_d = ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/pipo_fifo.sv
// pipo_fifo: synchronous show-ahead FIFO with sticky overflow/underflow flags.
//   clk_i   : clock (rising edge)
//   rst_i   : asynchronous active-high reset
//   clr_i   : synchronous flush, overrides wr_i/rd_i
//   wr_i    : write request, din_i sampled when accepted
//   din_i   : write data
//   rd_i    : read request, pops the head word
//   dout_o  : head word, zero while empty
//   empty_o : no words stored
//   full_o  : Depth words stored
//   count_o : number of stored words 0..Depth
//   ovf_o   : sticky, write attempted while full without a read
//   udf_o   : sticky, read attempted while empty
module pipo_fifo
  import pipo_fifo_pkg::*;
#(
  parameter int Width = DEFAULT_WIDTH,
  parameter int Depth = DEFAULT_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        wr_i,
  input  logic [Width-1:0]            din_i,
  input  logic                        rd_i,
  output logic [Width-1:0]            dout_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [cnt_width(Depth)-1:0] count_o,
  output logic                        ovf_o,
  output logic                        udf_o
);

  localparam int PW = ptr_width(Depth);
  localparam int CW = cnt_width(Depth);

  logic [PW-1:0]    wr_ptr_s;
  logic [PW-1:0]    rd_ptr_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             empty_s;
  logic             full_s;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             udf_d;
  logic             udf_q;
  logic [Width-1:0] mem_q [Depth];

  // Flags come only from the registered count, never from the inputs.
  assign empty_s = (count_q == CW'(0));
  assign full_s  = (count_q == CW'(Depth));

  // Acceptance: a read frees a slot in the same cycle, so a full FIFO
  // still accepts a write paired with a read.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (clr_i) begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end else begin
      rd_acc_s = rd_i & ~empty_s;
      wr_acc_s = wr_i & (~full_s | rd_i);
    end
  end

  // Next count and sticky error flags.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr_i) begin
      count_d = {CW{1'b0}};
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr_i & full_s & ~rd_i) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (rd_i & empty_s) begin
        udf_d = 1'b1;
      end else begin
        udf_d = udf_q;
      end
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; deliberately unreset so it can map onto RAM/register files.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_s] <= din_i;
    end
  end

  fifo_ptr #(.Depth(Depth)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (wr_acc_s),
    .ptr_o (wr_ptr_s)
  );

  fifo_ptr #(.Depth(Depth)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (rd_acc_s),
    .ptr_o (rd_ptr_s)
  );

  // Masking with empty keeps uninitialised storage off the output.
  assign dout_o  = empty_s ? {Width{1'b0}} : mem_q[rd_ptr_s];
  assign empty_o = empty_s;
  assign full_o  = full_s;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: tb/tb_pipo_fifo.sv
// tb_pipo_fifo: randomized and directed checks of pipo_fifo (Width=8, Depth=4)
// against a queue-based reference model.
module tb_pipo_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clr_i;
  logic       wr_i;
  logic [7:0] din_i;
  logic       rd_i;
  logic [7:0] dout_o;
  logic       empty_o;
  logic       full_o;
  logic [2:0] count_o;
  logic       ovf_o;
  logic       udf_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  bit         m_ovf;
  bit         m_udf;

  pipo_fifo #(.Width(8), .Depth(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .wr_i    (wr_i),
    .din_i   (din_i),
    .rd_i    (rd_i),
    .dout_o  (dout_o),
    .empty_o (empty_o),
    .full_o  (full_o),
    .count_o (count_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  always #5 clk_i = ~clk_i;

  // {count, empty, full, ovf, udf, dout}
  function automatic logic [14:0] obs_vec();
    return {count_o, empty_o, full_o, ovf_o, udf_o, dout_o};
  endfunction

  function automatic logic [14:0] model_vec();
    logic [7:0] head;
    int         n;
    n    = model_q.size();
    head = (n > 0) ? model_q[0] : 8'h00;
    return {3'(n), (n == 0), (n == 4), m_ovf, m_udf, head};
  endfunction

  function automatic void model_clear();
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  // Apply one clock of stimulus and advance the reference model.
  task automatic drive(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
    bit was_full;
    bit was_empty;
    wr_i  = wr;
    din_i = din;
    rd_i  = rd;
    clr_i = clr;
    @(posedge clk_i);
    if (clr) begin
      model_clear();
    end else begin
      was_full  = (model_q.size() == 4);
      was_empty = (model_q.size() == 0);
      if (wr && was_full && !rd) m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      if (rd && !was_empty) void'(model_q.pop_front());
      if (wr && (!was_full || rd)) model_q.push_back(din);
    end
    #1;
    wr_i  = 1'b0;
    rd_i  = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clr_i = 1'b0;
    wr_i  = 1'b0;
    rd_i  = 1'b0;
    din_i = 8'h00;
    model_clear();
    #2;
    n_checks++;
    if (obs_vec() !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0, 1'b0);
    n_checks++;
    if ({full_o, count_o} !== {1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=4", full_o, count_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout_o !== vals[i]) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %h expected %h", i, dout_o, vals[i]);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_checks++;
    if ({empty_o, dout_o} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL drain_empty: got empty=%b dout=%h expected empty=1 dout=00", empty_o, dout_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    n_checks++;
    if ({ovf_o, count_o} !== {1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL overflow_flag: got ovf=%b count=%0d expected ovf=1 count=4", ovf_o, count_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout_o !== vals[i]) begin
        n_fail++;
        $display("FAIL overflow_contents[%0d]: got %h expected %h", i, dout_o, vals[i]);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_checks++;
    if ({empty_o, ovf_o} !== {1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_sticky: got empty=%b ovf=%b expected empty=1 ovf=1", empty_o, ovf_o);
    end
  endtask

  task automatic test_underflow_simul();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    n_checks++;
    if ({udf_o, count_o, dout_o} !== {1'b1, 3'd1, 8'hA5}) begin
      n_fail++;
      $display("FAIL underflow_simul: got udf=%b count=%0d dout=%h expected udf=1 count=1 dout=a5",
               udf_o, count_o, dout_o);
    end
    drive(1'b1, 8'hB6, 1'b0, 1'b0);
    drive(1'b1, 8'hC7, 1'b0, 1'b0);
    drive(1'b1, 8'hD8, 1'b0, 1'b0);
    drive(1'b1, 8'hE9, 1'b1, 1'b0);
    n_checks++;
    if ({full_o, count_o, dout_o, ovf_o} !== {1'b1, 3'd4, 8'hB6, 1'b0}) begin
      n_fail++;
      $display("FAIL full_simul: got full=%b count=%0d dout=%h ovf=%b expected full=1 count=4 dout=b6 ovf=0",
               full_o, count_o, dout_o, ovf_o);
    end
    n_checks++;
    if (obs_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL full_simul_model: got %h expected %h", obs_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d = 8'h01;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 3; k++) drive(1'b1, d + 8'(k), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (dout_o !== d + 8'(k)) begin
          n_fail++;
          $display("FAIL wrap_order[%0d.%0d]: got %h expected %h", it, k, dout_o, d + 8'(k));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
      end
      n_checks++;
      if (count_o !== 3'd0) begin
        n_fail++;
        $display("FAIL wrap_count[%0d]: got %0d expected 0", it, count_o);
      end
      d = d + 8'd3;
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({count_o, ovf_o} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_setup: got count=%0d ovf=%b expected count=3 ovf=1", count_o, ovf_o);
    end
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    n_checks++;
    if (obs_vec() !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL flush_result: got %h expected %h", obs_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    n_checks++;
    if ({count_o, dout_o} !== {3'd1, 8'h3C}) begin
      n_fail++;
      $display("FAIL flush_after: got count=%0d dout=%h expected count=1 dout=3c", count_o, dout_o);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    drive(1'b1, 8'h43, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h65, 1'b0, 1'b0);
    #3;
    rst_i = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (obs_vec() !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    #2;
    rst_i = 1'b0;
    drive(1'b1, 8'h87, 1'b0, 1'b0);
    n_checks++;
    if ({count_o, dout_o} !== {3'd1, 8'h87}) begin
      n_fail++;
      $display("FAIL reset_first_write: got count=%0d dout=%h expected count=1 dout=87", count_o, dout_o);
    end
  endtask

  task automatic test_random();
    bit         wr;
    bit         rd;
    bit         clr;
    logic [7:0] din;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 500; c++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 3);
      din = 8'($urandom);
      drive(wr, din, rd, clr);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h (wr=%b rd=%b clr=%b din=%h)",
                 c, obs_vec(), model_vec(), wr, rd, clr, din);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
